// File: rtl/avalon_st_rr_arbiter.sv
// Round-robin arbiter merging N Avalon-ST sources into one registered sink stream, bounded bursts per grant.
// Optional macro AVST_ARB_CHANNEL_EN adds src_channel_o carrying the source index of each output beat.
module avalon_st_rr_arbiter #(
    parameter int N          = 4,
    parameter int DATA_WIDTH = 16,
    parameter int BURST_LEN  = 4,
    localparam int IDX_W     = $clog2(N),
    localparam int CNT_W     = $clog2(BURST_LEN + 1)
) (
    input  logic                    clk_i,
    input  logic                    srst_i,
    input  logic [N*DATA_WIDTH-1:0] snk_data_i,
    input  logic [N-1:0]            snk_valid_i,
    output logic [N-1:0]            snk_ready_o,
    output logic [DATA_WIDTH-1:0]   src_data_o,
    output logic                    src_valid_o,
    input  logic                    src_ready_i,
`ifdef AVST_ARB_CHANNEL_EN
    output logic [IDX_W-1:0]        src_channel_o,
`endif
    output logic [N-1:0]            grant_o,
    output logic                    busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [N-1:0]            grant_q, grant_d;
    logic [IDX_W-1:0]        last_grant_q, last_grant_d;
    logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
    logic                    src_valid_q;
    logic [DATA_WIDTH-1:0]   src_data_q;

    logic                    load_en;
    logic                    accept;
    logic                    granted_valid;
    logic                    pick_found;
    logic [IDX_W-1:0]        pick_idx;
    logic [IDX_W-1:0]        cand_idx;
    int                      cand;
    logic [DATA_WIDTH-1:0]   snk_data_arr [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign snk_data_arr[gi] = snk_data_i[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    assign load_en       = !src_valid_q || src_ready_i;
    assign granted_valid = |(grant_q & snk_valid_i);
    assign snk_ready_o   = (state_q == GRANT) ? (grant_q & {N{load_en}}) : '0;

    // Search starts just after the previous winner so every requester gets a turn.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = last_grant_q;
        cand       = 0;
        cand_idx   = '0;
        for (int i = 1; i <= N; i++) begin
            cand = int'(last_grant_q) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = IDX_W'(cand);
            if (!pick_found && snk_valid_i[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        accept       = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d      = GRANT;
                    grant_d      = {{(N-1){1'b0}}, 1'b1} << pick_idx;
                    last_grant_d = pick_idx;
                    beat_cnt_d   = '0;
                end
            end
            GRANT: begin
                if (!granted_valid) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if (load_en) begin
                    accept = 1'b1;
                    if (beat_cnt_q == CNT_W'(BURST_LEN - 1)) begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(N - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    // Output stage: one beat of buffering; data only moves when the register can take a beat.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            src_valid_q <= 1'b0;
            src_data_q  <= '0;
        end else if (load_en) begin
            src_valid_q <= accept;
            if (accept) begin
                src_data_q <= snk_data_arr[last_grant_q];
            end
        end
    end

`ifdef AVST_ARB_CHANNEL_EN
    logic [IDX_W-1:0] src_channel_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            src_channel_q <= '0;
        end else if (load_en && accept) begin
            src_channel_q <= last_grant_q;
        end
    end

    assign src_channel_o = src_channel_q;
`endif

    assign src_valid_o = src_valid_q;
    assign src_data_o  = src_data_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q == GRANT);

endmodule

// File: tb/tb_avalon_st_rr_arbiter.sv
// Directed scoreboard bench for avalon_st_rr_arbiter; channel checks active when AVST_ARB_CHANNEL_EN is defined.
module tb_avalon_st_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int BL = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            srst = 1'b1;
    logic [N*DW-1:0] snk_data = '0;
    logic [N-1:0]    snk_valid = '0;
    logic [N-1:0]    snk_ready;
    logic [DW-1:0]   src_data;
    logic            src_valid;
    logic            src_ready = 1'b1;
    logic [N-1:0]    grant;
    logic            busy;
`ifdef AVST_ARB_CHANNEL_EN
    logic [IW-1:0]   src_channel;
`endif

    always #5 clk = ~clk;

    avalon_st_rr_arbiter #(.N(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk_i        (clk),
        .srst_i       (srst),
        .snk_data_i   (snk_data),
        .snk_valid_i  (snk_valid),
        .snk_ready_o  (snk_ready),
        .src_data_o   (src_data),
        .src_valid_o  (src_valid),
        .src_ready_i  (src_ready),
`ifdef AVST_ARB_CHANNEL_EN
        .src_channel_o(src_channel),
`endif
        .grant_o      (grant),
        .busy_o       (busy)
    );

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  ch;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] sq[N][$];
    int          tests = 0;
    int          fails = 0;

    function automatic logic [15:0] word(input int t, input int k, input int i);
        return 16'(((k + 1) << 12) | (t << 8) | i);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic load_src(input int t, input int k, input int n);
        for (int i = 0; i < n; i++) sq[k].push_back(word(t, k, i));
    endtask

    task automatic push_exp(input int t, input int k, input int first, input int n);
        exp_t e;
        for (int i = first; i < first + n; i++) begin
            e.d  = word(t, k, i);
            e.ch = 4'(k);
            exp_q.push_back(e);
        end
    endtask

    task automatic apply_src();
        for (int k = 0; k < N; k++) begin
            if (sq[k].size() > 0) begin
                snk_valid[k]            = 1'b1;
                snk_data[k*DW +: DW]    = sq[k][0];
            end else begin
                snk_valid[k] = 1'b0;
            end
        end
    endtask

    // Sample handshakes before the edge, retire the taken words just after it.
    task automatic cycle();
        logic [N-1:0] take;
        @(negedge clk);
        take = snk_valid & snk_ready;
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) if (take[k]) void'(sq[k].pop_front());
        apply_src();
    endtask

    task automatic clear_all();
        for (int k = 0; k < N; k++) sq[k].delete();
        exp_q.delete();
        apply_src();
    endtask

    task automatic do_reset();
        srst      = 1'b1;
        src_ready = 1'b1;
        clear_all();
        cycle();
        cycle();
        check("rst_src_valid", 32'(src_valid), 32'd0);
        check("rst_src_data", 32'(src_data), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_snk_ready", 32'(snk_ready), 32'd0);
        clear_all();
        srst = 1'b0;
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 300;
        while (exp_q.size() > 0 && budget > 0) begin
            cycle();
            budget--;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every output transfer.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!srst && src_valid && src_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got 0x%0h expected no beat", src_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 32'(src_data), 32'(e.d));
`ifdef AVST_ARB_CHANNEL_EN
                    check("beat_channel", 32'(src_channel), 32'(e.ch));
`endif
                end
            end
        end
    end

    initial begin
        exp_t e;

        // T1: only source 2, ten words, bursts of four
        do_reset();
        for (int i = 0; i < 10; i++) begin
            sq[2].push_back(16'h0100 + 16'(i));
            e.d  = 16'h0100 + 16'(i);
            e.ch = 4'd2;
            exp_q.push_back(e);
        end
        apply_src();
        cycle();
        check("t1_first_grant", 32'(grant), 32'b0100);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_snk_ready", 32'(snk_ready), 32'b0100);
        drain("t1_drained");

        // T2: all sources continuously valid; 4 high / 1 low, grants 0,1,2,3
        do_reset();
        for (int k = 0; k < N; k++) load_src(2, k, 8);
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < N; k++) push_exp(2, k, r * 4, 4);
        apply_src();
        for (int c = 1; c <= 21; c++) begin
            cycle();
            if ((c - 1) % 5 == 0 && c <= 16)
                check("t2_grant", 32'(grant), 32'(1 << (((c - 1) / 5) % 4)));
            if (c >= 2)
                check("t2_valid_pattern", 32'(src_valid), 32'(((c - 2) % 5) < 4));
        end
        drain("t2_drained");

        // T3: source 1 runs dry after two beats, grant passes to source 2
        do_reset();
        load_src(3, 1, 2);
        load_src(3, 2, 4);
        push_exp(3, 1, 0, 2);
        push_exp(3, 2, 0, 4);
        apply_src();
        cycle();
        check("t3_grant_src1", 32'(grant), 32'b0010);
        cycle();
        cycle();
        cycle();
        check("t3_early_release", 32'(grant), 32'd0);
        cycle();
        check("t3_next_grant_src2", 32'(grant), 32'b0100);
        drain("t3_drained");

        // T4: downstream stall of three cycles mid-burst
        do_reset();
        load_src(4, 0, 6);
        push_exp(4, 0, 0, 6);
        apply_src();
        cycle();
        check("t4_grant", 32'(grant), 32'b0001);
        cycle();
        cycle();
        check("t4_data_before_stall", 32'(src_data), 32'(word(4, 0, 1)));
        src_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("t4_stall_valid", 32'(src_valid), 32'd1);
            check("t4_stall_data", 32'(src_data), 32'(word(4, 0, 1)));
            check("t4_stall_snk_ready", 32'(snk_ready), 32'd0);
            check("t4_stall_grant", 32'(grant), 32'b0001);
        end
        src_ready = 1'b1;
        cycle();
        check("t4_burst_not_ended", 32'(grant), 32'b0001);
        cycle();
        check("t4_burst_end_grant", 32'(grant), 32'd0);
        check("t4_burst_end_busy", 32'(busy), 32'd0);
        drain("t4_drained");

        // T5: reset pulse while an output beat is held
        do_reset();
        load_src(5, 2, 8);
        load_src(5, 3, 4);
        push_exp(5, 2, 0, 1);
        apply_src();
        cycle();
        check("t5_grant", 32'(grant), 32'b0100);
        cycle();
        cycle();
        check("t5_valid_before_rst", 32'(src_valid), 32'd1);
        check("t5_first_beat_out", 32'(exp_q.size()), 32'd0);
        srst      = 1'b1;
        src_ready = 1'b0;
        cycle();
        check("t5_rst_valid", 32'(src_valid), 32'd0);
        check("t5_rst_data", 32'(src_data), 32'd0);
        check("t5_rst_grant", 32'(grant), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_snk_ready", 32'(snk_ready), 32'd0);
        clear_all();
        load_src(6, 1, 4);
        load_src(6, 3, 4);
        push_exp(6, 1, 0, 4);
        push_exp(6, 3, 0, 4);
        apply_src();
        srst      = 1'b0;
        src_ready = 1'b1;
        cycle();
        check("t5_lowest_after_rst", 32'(grant), 32'b0010);
        drain("t5_drained");

        // T6: sources 0 and 3 interleaved (channel tagging when enabled)
        do_reset();
        load_src(7, 0, 6);
        load_src(7, 3, 6);
        push_exp(7, 0, 0, 4);
        push_exp(7, 3, 0, 4);
        push_exp(7, 0, 4, 2);
        push_exp(7, 3, 4, 2);
        apply_src();
        drain("t6_drained");

        for (int c = 0; c < 4; c++) cycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/avalon_st_rr_arbiter.md
Name: avalon_st_rr_arbiter

Overview:
- Shares one avalon_st_if sink (data/valid/ready, no packet signals) between N avalon_st_if sources.
- Uses round-robin grants, each held for a bounded burst of beats.
- Sits in the audio datapath where several processing stages feed one shared consumer (e.g. one effect core or output serializer).
- Output stage is registered: one beat of buffering, full throughput inside a burst.

Parameters:
- N, 4, number of requesting sources (2..16)
- DATA_WIDTH, 16, data width of every stream
- BURST_LEN, 4, maximum beats accepted per grant (>=1)

Ports:
- clk_i  in  1  clock
- srst_i  in  1  synchronous active-high reset
- snk_data_i  in  N*DATA_WIDTH  source k data at bits [k*DATA_WIDTH +: DATA_WIDTH]
- snk_valid_i  in  N  per-source valid
- snk_ready_o  out  N  per-source ready
- src_data_o  out  DATA_WIDTH  merged stream data (registered)
- src_valid_o  out  1  merged stream valid (registered)
- src_ready_i  in  1  downstream ready
- grant_o  out  N  one-hot current grant; zero in IDLE
- busy_o  out  1  high in GRANT state

Behaviour:
- One clock domain; srst_i synchronous and active-high.
- Reset values:
  - src_valid_o=0, src_data_o=0, grant_o=0, busy_o=0, snk_ready_o=0.
  - State IDLE, beat_cnt=0, last_grant=N-1, so the first arbitration favours source 0.
- Handshake: a beat transfers on a side when valid && ready are both high that cycle. Ready latency is 0.
- Output register:
  - load_en = !src_valid_o || src_ready_i.
  - When load_en: src_valid_o <= accepted beat, src_data_o <= that beat's data. src_data_o holds its value when no beat is accepted.
  - Latency from sink accept to src_valid_o is 1 cycle.
- snk_ready_o[k] = (state==GRANT) && grant_o[k] && load_en. Combinational from src_ready_i, src_valid_o and state. It never depends on snk_valid_i.
- FSM:
  - IDLE: if |snk_valid_i, pick the first asserted index searching last_grant+1, last_grant+2, ... modulo N. Then grant_o <= onehot(pick), last_grant <= pick, beat_cnt <= 0, go to GRANT. If nothing is valid, stay in IDLE.
  - GRANT, on an accepted beat: beat_cnt++. If beat_cnt==BURST_LEN-1, go to IDLE and clear grant_o.
  - GRANT, granted source's valid low: go to IDLE, clear grant_o, no beat accepted. Early release.
  - GRANT, valid high but load_en low: hold grant and count (backpressure stall).
- IDLE always costs one bubble cycle between grants. No sink is ready in IDLE.
- Fairness: a source that keeps valid high is granted again only after every other requesting source has had one grant.
- Requests arriving while another source is granted wait; they are never dropped.
- Per-source ordering is preserved. Data from different grants is never interleaved within one burst.
- beat_cnt width: $clog2(BURST_LEN+1), saturating logic not needed.
- Reset mid-burst: the in-flight registered beat is discarded and src_valid_o drops in the next cycle.
- src_valid_o and src_data_o stay stable while src_valid_o && !src_ready_i (Avalon-ST stability).
- Sources are assumed to hold data while valid && !ready. The block does not check this.

Optional Feature:
- Macro: AVST_ARB_CHANNEL_EN.
- Defined:
  - Adds output port src_channel_o, width $clog2(N), reset 0.
  - Carries the index of the source that produced the beat in the output register. It loads with src_data_o under load_en.
- Undefined: port absent, no channel register; all other behaviour identical.

Test Plan:
- N=4, BURST_LEN=4, only source 2 valid with data 0x0100..0x0109, src_ready_i=1:
  - grant_o=0b0100 in cycle 2 after reset release.
  - Bursts of 4 beats, 1-cycle bubble between grants, all 10 words out in order.
- Sources 0..3 all valid continuously, src_ready_i=1:
  - Grant order 0,1,2,3,0,... with exactly 4 beats each.
  - src_valid_o pattern 4 high / 1 low.
- Source 1 drops valid after 2 beats of a grant:
  - Early release after 2 beats, IDLE, next grant goes to source 2 if it is valid.
- src_ready_i low for 3 cycles mid-burst:
  - src_valid_o and src_data_o frozen, snk_ready_o all 0, beat_cnt unchanged.
  - Burst resumes and completes 4 beats total.
- srst_i pulsed during a burst with src_valid_o=1:
  - Next cycle all outputs at reset values.
  - The following first grant goes to the lowest valid index.
- With AVST_ARB_CHANNEL_EN, sources 0 and 3 interleaved:
  - src_channel_o equals 0 on every beat carrying source 0 data and 3 on every beat carrying source 3 data.
